adder_pipe: RTL and testbench
=============================

ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, number of pipeline stages; slice width SW = WIDTH/STAGES.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  operands valid.
REQ-006 The block SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 The block SHALL have ports a and b  input  WIDTH each  operands, unsigned or two's complement.
REQ-008 The block SHALL have port cin  input  1  carry-in, used in add mode only.
REQ-009 The block SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-010 The block SHALL have port out_valid  output  1  result valid.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 The block SHALL have port sum  output  WIDTH  result.
REQ-013 The block SHALL have port cout  output  1  carry-out of MSB.
REQ-014 The block SHALL have port ovf  output  1  signed overflow.

Function
REQ-015 An operand set SHALL be accepted when in_valid && in_ready at a rising edge.
REQ-016 Add mode SHALL compute a + b + cin; sub mode SHALL compute a + ~b + 1, with cin ignored.
REQ-017 Stage k (0..STAGES-1) SHALL add slice k (bits k*SW+SW-1 .. k*SW) using the carry registered by stage k-1; stage 0 uses the mode carry-in.
REQ-018 Higher operand slices SHALL be delayed and lower result slices carried forward, so that each stage holds exactly one transaction.
REQ-019 Latency SHALL be STAGES cycles: a transaction accepted at edge N SHALL present out_valid=1 after edge N+STAGES-1, with no stalls.
REQ-020 cout SHALL be the carry out of bit WIDTH-1; in sub mode, cout=1 SHALL mean no borrow.
REQ-021 ovf SHALL be (carry into MSB) XOR (carry out of MSB).
REQ-022 Each stage SHALL carry a valid bit; bubbles SHALL propagate and SHALL NOT be collapsed.
REQ-023 stall SHALL be defined as out_valid && !out_ready.
REQ-024 When stall=1, the whole pipeline SHALL hold, with all registers unchanged.
REQ-025 in_ready SHALL equal !stall, combinationally from out_ready.
REQ-026 A full pipeline whose output is accepted SHALL accept a new input in the same cycle.
REQ-027 sum, cout and ovf SHALL hold stable while out_valid && !out_ready.
REQ-028 sum, cout and ovf are don't-care when out_valid=0.
REQ-029 Results SHALL leave the pipeline in acceptance order.
REQ-030 STAGES=1 SHALL reduce the block to a single registered adder with latency 1.
REQ-031 WIDTH not divisible by STAGES, STAGES<1, or WIDTH<2 SHALL be an elaboration error.

Reset
REQ-032 While rst=1 at an edge, all stage valid bits SHALL clear.
REQ-033 After reset, out_valid=0, in_ready=1, and sum, cout and ovf SHALL be 0.
REQ-034 Reset mid-operation SHALL discard all in-flight transactions; no result of them SHALL appear afterwards.
REQ-035 in_valid SHALL be ignored during any cycle in which rst=1.

Structure
REQ-036 The shared package SHALL hold the default WIDTH and STAGES constants and the mode encoding (ADD=0, SUB=1).
REQ-037 One sub-module, adder_slice, SHALL implement a registered SW-bit ripple add with carry-in/out and MSB carry-in tap, built from the existing full_adder cell, and SHALL be instantiated STAGES times by generate loop.

Verification
REQ-038 a=0xFFFFFFFF, b=1, cin=0, add SHALL give sum=0x00000000, cout=1, ovf=0, 4 cycles later.
REQ-039 a=0x7FFFFFFF, b=1, add SHALL give sum=0x80000000, cout=0, ovf=1.
REQ-040 a=5, b=7, sub=1, cin=1 SHALL give sum=0xFFFFFFFE, cout=0, ovf=0 (cin ignored).
REQ-041 8 back-to-back operand sets with out_ready=1 SHALL give out_valid on 8 consecutive cycles starting at latency 4, in order, matching the reference model.
REQ-042 A stream with out_ready=0 for 3 cycles while full SHALL give in_ready=0 for those cycles, sum held stable, and no loss or duplication on release.
REQ-043 rst pulsed with 3 transactions in flight SHALL give out_valid=0 next cycle, none of the 3 results ever emitted, and the next new transaction correct.

Source files
------------

// File: rtl/adder_pipe_pkg.sv
// Shared constants for the pipelined adder: default geometry and the add/sub mode encoding.
package adder_pipe_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/adder_slice.sv
// Registered SW-bit ripple adder built from full_adder cells; one cycle latency, holds when en_i=0.
// Also registers the carry into its MSB so the top slice can form signed overflow.
module adder_slice #(
  parameter int SW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          ci_i,
  output logic [SW-1:0] s_o,
  output logic          co_o,
  output logic          cm_o
);

  logic [SW-1:0] s_d;
  logic [SW-1:0] s_q;
  logic          co_q;
  logic          cm_q;

  // Per-bit carry wires keep the ripple chain as distinct nets.
  for (genvar i = 0; i < SW; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_lsb
      assign ci = ci_i;
    end else begin : g_chain
      assign ci = g_bit[i-1].co;
    end
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (ci),
      .s_o (s_d[i]),
      .c_o (co)
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q  <= '0;
      co_q <= 1'b0;
      cm_q <= 1'b0;
    end else if (en_i) begin
      s_q  <= s_d;
      co_q <= g_bit[SW-1].co;
      cm_q <= g_bit[SW-1].ci;
    end
  end

  assign s_o  = s_q;
  assign co_o = co_q;
  assign cm_o = cm_q;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell; purely combinational.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/adder_pipe.sv
// STAGES-deep carry-pipelined add/sub, one SW-bit slice per stage; latency STAGES cycles.
// Whole pipeline freezes while the output is valid and not accepted; in_ready = !stall.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = (STAGES >= 1) ? WIDTH / STAGES : 1;

  if (STAGES < 1 || WIDTH < 2 || (WIDTH % ((STAGES >= 1) ? STAGES : 1)) != 0) begin : g_param_check
    $error("adder_pipe: WIDTH must be >= 2 and divisible by STAGES >= 1");
  end

  mode_e            mode;
  logic [WIDTH-1:0] b_eff;
  logic             ci0;
  logic             stall;
  logic             en;

  assign mode     = mode_e'(sub);
  assign b_eff    = (mode == MODE_SUB) ? ~b : b;
  assign ci0      = (mode == MODE_SUB) ? 1'b1 : cin;
  assign in_ready = ~stall;
  assign en       = ~stall;

  if (STAGES == 1) begin : g_single
    logic          vld_q;
    logic          vld_d;
    logic [SW-1:0] sl_s;
    logic          sl_co;
    logic          sl_cm;

    adder_slice #(.SW(SW)) u_slice (
      .clk_i (clk),
      .rst_i (rst),
      .en_i  (en),
      .a_i   (a),
      .b_i   (b_eff),
      .ci_i  (ci0),
      .s_o   (sl_s),
      .co_o  (sl_co),
      .cm_o  (sl_cm)
    );

    assign vld_d = in_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
      end else if (en) begin
        vld_q <= vld_d;
      end
    end

    assign stall     = vld_q & ~out_ready;
    assign out_valid = vld_q;
    assign sum       = sl_s;
    assign cout      = sl_co;
    assign ovf       = sl_co ^ sl_cm;

  end else begin : g_multi
    localparam int PW = WIDTH - SW;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [SW-1:0]     sl_a [STAGES];
    logic [SW-1:0]     sl_b [STAGES];
    logic [SW-1:0]     sl_s [STAGES];
    logic [STAGES-1:0] sl_ci;
    logic [STAGES-1:0] sl_co;
    logic [STAGES-1:0] sl_cm;
    logic [WIDTH-1:0]  xa   [STAGES];
    // pa_q: finished low sum slices on top of the not-yet-added a slices; pb_q: pending b slices.
    logic [PW-1:0]     pa_q [STAGES];
    logic [PW-1:0]     pa_d [STAGES];
    logic [PW-1:0]     pb_q [STAGES-1];
    logic [PW-1:0]     pb_d [STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_slice #(.SW(SW)) u_slice (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (en),
        .a_i   (sl_a[k]),
        .b_i   (sl_b[k]),
        .ci_i  (sl_ci[k]),
        .s_o   (sl_s[k]),
        .co_o  (sl_co[k]),
        .cm_o  (sl_cm[k])
      );
    end

    always_comb begin
      vld_d   = {vld_q[STAGES-2:0], in_valid};
      xa[0]   = a;
      sl_b[0] = b_eff[SW-1:0];
      pb_d[0] = b_eff[WIDTH-1:SW];
      sl_ci   = '0;
      sl_ci[0] = ci0;
      for (int k = 1; k < STAGES; k++) begin
        xa[k]    = {sl_s[k-1], pa_q[k-1]};
        sl_b[k]  = pb_q[k-1][SW-1:0];
        sl_ci[k] = sl_co[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        sl_a[k] = xa[k][SW-1:0];
        pa_d[k] = xa[k][WIDTH-1:SW];
      end
      for (int k = 1; k < STAGES-1; k++) begin
        pb_d[k] = pb_q[k-1] >> SW;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        for (int k = 0; k < STAGES; k++) pa_q[k] <= '0;
        for (int k = 0; k < STAGES-1; k++) pb_q[k] <= '0;
      end else if (en) begin
        vld_q <= vld_d;
        for (int k = 0; k < STAGES; k++) pa_q[k] <= pa_d[k];
        for (int k = 0; k < STAGES-1; k++) pb_q[k] <= pb_d[k];
      end
    end

    // Only the last stage's MSB carry-in and the low b slice of the last pb word are consumed.
    logic unused_cm;
    assign unused_cm = ^sl_cm;
    if (STAGES > 2) begin : g_sink
      logic unused_b;
      assign unused_b = ^(pb_q[STAGES-2] >> SW);
    end

    assign stall     = vld_q[STAGES-1] & ~out_ready;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = {sl_s[STAGES-1], pa_q[STAGES-1]};
    assign cout      = sl_co[STAGES-1];
    assign ovf       = sl_co[STAGES-1] ^ sl_cm[STAGES-1];
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Directed, table-driven bench for adder_pipe at WIDTH=32, STAGES=4.
module tb_adder_pipe;

  localparam int W = 32;
  localparam int S = 4;
  localparam int NV = 13;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vt [NV];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
    sub      = v.sub;
    in_valid = vld;
  endtask

  // Starts just after a negedge; sends one vector into an empty pipe and checks latency and result.
  task automatic run_one(input string nm, input vec_t v);
    int lat;
    bit seen;
    seen = 1'b0;
    lat  = 0;
    drive(v, 1'b1);
    chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    for (int t = 1; t <= 10 && !seen; t++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) begin
        seen = 1'b1;
        lat  = t;
      end
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_latency"}, lat, S);
      chk({nm, "_sum"}, sum, v.s);
      chk({nm, "_cout"}, {31'd0, cout}, {31'd0, v.co});
      chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, v.ov});
    end
  endtask

  task automatic stream_test();
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      #1;
      chk($sformatf("b2b_vld_c%0d", cyc), {31'd0, out_valid}, {31'd0, (cyc >= S && cyc < S + 8)});
      if (out_valid && cyc >= S && cyc < S + 8) begin
        chk($sformatf("b2b_sum_%0d", cyc - S), sum, vt[cyc-S].s);
        chk($sformatf("b2b_cout_%0d", cyc - S), {31'd0, cout}, {31'd0, vt[cyc-S].co});
        chk($sformatf("b2b_ovf_%0d", cyc - S), {31'd0, ovf}, {31'd0, vt[cyc-S].ov});
      end
      if (cyc < 8) drive(vt[cyc], 1'b1);
      else         in_valid = 1'b0;
    end
  endtask

  task automatic stall_test();
    vec_t        q[$];
    vec_t        e;
    int          sent;
    int          got;
    int          stalls;
    logic [31:0] held;
    sent   = 0;
    got    = 0;
    stalls = 0;
    held   = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc <= 8);
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        if (cyc == 6) held = sum;
        else          chk($sformatf("stall_hold_c%0d", cyc), sum, held);
        chk($sformatf("stall_in_ready_c%0d", cyc), {31'd0, in_ready}, 32'd0);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stall_extra_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("stall_sum_%0d", got), sum, e.s);
          chk($sformatf("stall_cout_%0d", got), {31'd0, cout}, {31'd0, e.co});
          got++;
        end
      end
      if (sent < 8) begin
        drive(vt[sent], 1'b1);
        if (in_ready) begin
          q.push_back(vt[sent]);
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    chk("stall_cycles", stalls, 3);
    chk("stall_sent", sent, 8);
    chk("stall_received", got, 8);
  endtask

  task automatic reset_test();
    int spurious;
    spurious = 0;
    for (int i = 0; i < 3; i++) begin
      drive(vt[9+i], 1'b1);
      @(negedge clk);
    end
    rst = 1'b1;
    drive(vt[3], 1'b1);
    @(negedge clk);
    #1;
    chk("rst_flush_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_sum_zero", sum, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      #1;
      if (out_valid) spurious++;
    end
    chk("rst_no_ghosts", spurious, 0);
    run_one("post_rst", vt[12]);
  endtask

  initial begin
    vt[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[3]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    vt[4]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vt[5]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vt[6]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[7]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0};
    vt[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vt[9]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    vt[10] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0};
    vt[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vt[12] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1};

    rst       = 1'b1;
    out_ready = 1'b1;
    drive(vt[0], 1'b1);
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_sum", sum, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_one($sformatf("vec%0d", i), vt[i]);
    end

    repeat (2) @(negedge clk);
    stream_test();
    repeat (6) @(negedge clk);
    stall_test();
    @(negedge clk);
    reset_test();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
